// File: rtl/branch_sequencer_if.sv
// Handshake and datapath strobe bundle between the main control unit and the
// conditional-branch sequencer.
interface branch_sequencer_if;
    logic        start;
    logic        hold;
    logic [31:0] ir;
    logic [31:0] bus_in;
    logic        gra;
    logic        r_out;
    logic        con_in;
    logic        pc_out;
    logic        y_in;
    logic        c_out;
    logic        alu_add;
    logic        z_in;
    logic        z_lo_out;
    logic        pc_in;
    logic        busy;
    logic        done;
    logic        taken;
    logic        illegal;

    modport master (
        output start, hold, ir, bus_in,
        input  gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
               z_lo_out, pc_in, busy, done, taken, illegal
    );

    modport slave (
        input  start, hold, ir, bus_in,
        output gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
               z_lo_out, pc_in, busy, done, taken, illegal
    );
endinterface

// File: rtl/branch_sequencer.sv
// Conditional branch sequencer: evaluates the CON condition on Ra, then
// computes PC + C and writes PC only when the condition holds.
module branch_sequencer #(
    parameter logic [4:0] BR_OPCODE = 5'b10011
) (
    input logic               clock,
    input logic               clear,
    branch_sequencer_if.slave bif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EVAL  = 3'd1,
        PCY   = 3'd2,
        ADD   = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   con_flag_r;
    logic   illegal_r;
    logic   illegal_s;
    logic   is_branch_s;

    // C2 selects zero / non-zero / positive / negative test on Ra
    function automatic logic eval_cond(input logic [1:0] c2, input logic [31:0] value);
        logic result;
        case (c2)
            2'b00:   result = (value == 32'd0);
            2'b01:   result = (value != 32'd0);
            2'b10:   result = (value[31] == 1'b0);
            2'b11:   result = (value[31] == 1'b1);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    assign is_branch_s = (bif.ir[31:27] == BR_OPCODE);

    // Next-state decode and illegal-start detection
    always_comb begin
        state_s   = state_r;
        illegal_s = 1'b0;
        if (bif.hold) begin
            state_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bif.start && is_branch_s) begin
                        state_s = EVAL;
                    end else begin
                        state_s = IDLE;
                    end
                    illegal_s = bif.start && !is_branch_s;
                end
                EVAL:    state_s = PCY;
                PCY:     state_s = ADD;
                ADD:     state_s = WRITE;
                WRITE:   state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State, CON flag and illegal pulse registers
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r    <= IDLE;
            con_flag_r <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            illegal_r <= illegal_s;
            if (state_r == EVAL && !bif.hold) begin
                con_flag_r <= eval_cond(bif.ir[20:19], bif.bus_in);
            end else begin
                con_flag_r <= con_flag_r;
            end
        end
    end

    // Strobe decode from state; a stall silences every strobe
    always_comb begin
        bif.gra      = 1'b0;
        bif.r_out    = 1'b0;
        bif.con_in   = 1'b0;
        bif.pc_out   = 1'b0;
        bif.y_in     = 1'b0;
        bif.c_out    = 1'b0;
        bif.alu_add  = 1'b0;
        bif.z_in     = 1'b0;
        bif.z_lo_out = 1'b0;
        bif.pc_in    = 1'b0;
        bif.done     = 1'b0;
        if (!bif.hold) begin
            case (state_r)
                EVAL: begin
                    bif.gra    = 1'b1;
                    bif.r_out  = 1'b1;
                    bif.con_in = 1'b1;
                end
                PCY: begin
                    bif.pc_out = 1'b1;
                    bif.y_in   = 1'b1;
                end
                ADD: begin
                    bif.c_out   = 1'b1;
                    bif.alu_add = 1'b1;
                    bif.z_in    = 1'b1;
                end
                WRITE: begin
                    bif.z_lo_out = 1'b1;
                    bif.pc_in    = con_flag_r;
                    bif.done     = 1'b1;
                end
                default: begin
                    bif.done = 1'b0;
                end
            endcase
        end else begin
            bif.done = 1'b0;
        end
    end

    assign bif.busy    = (state_r != IDLE);
    assign bif.taken   = con_flag_r & bif.done;
    assign bif.illegal = illegal_r;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed, table-driven bench for branch_sequencer with hand-written
// sequences for stalls, ignored starts and mid-sequence clear.
module tb_branch_sequencer;

    logic clock;
    logic clear;
    int   total;
    int   bad;

    branch_sequencer_if bif ();

    branch_sequencer #(.BR_OPCODE(5'b10011)) dut (
        .clock (clock),
        .clear (clear),
        .bif   (bif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // bit order: gra r_out con_in pc_out y_in c_out alu_add z_in z_lo_out pc_in busy done taken illegal
    localparam logic [13:0] V_IDLE   = 14'b00000000000000;
    localparam logic [13:0] V_EVAL   = 14'b11100000001000;
    localparam logic [13:0] V_PCY    = 14'b00011000001000;
    localparam logic [13:0] V_ADD    = 14'b00000111001000;
    localparam logic [13:0] V_WR_T   = 14'b00000000111110;
    localparam logic [13:0] V_WR_N   = 14'b00000000101100;
    localparam logic [13:0] V_HELD   = 14'b00000000001000;
    localparam logic [13:0] V_ILLEG  = 14'b00000000000001;

    logic [13:0] obs;
    assign obs = {bif.gra, bif.r_out, bif.con_in, bif.pc_out, bif.y_in, bif.c_out,
                  bif.alu_add, bif.z_in, bif.z_lo_out, bif.pc_in, bif.busy,
                  bif.done, bif.taken, bif.illegal};

    typedef struct {
        logic [31:0] ir;
        logic [31:0] bus;
        logic        tk;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [13:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, obs, exp, $time);
        end
    endtask

    // Called at a negedge in an IDLE cycle; returns at the negedge of the first IDLE cycle after WRITE
    task automatic run_branch(input string name, input logic [31:0] ir, input logic [31:0] bus,
                              input logic tk);
        bif.ir     = ir;
        bif.bus_in = bus;
        bif.start  = 1'b1;
        @(posedge clock);
        #1 bif.start = 1'b0;
        @(negedge clock); check({name, "_eval"}, V_EVAL);
        @(negedge clock); check({name, "_pcy"},  V_PCY);
        @(negedge clock); check({name, "_add"},  V_ADD);
        @(negedge clock); check({name, "_write"}, tk ? V_WR_T : V_WR_N);
        @(negedge clock); check({name, "_idle"}, V_IDLE);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{32'h99000019, 32'h00000000, 1'b1};  // brzr taken
        vecs[1] = '{32'h99000019, 32'h00000005, 1'b0};  // brzr not taken
        vecs[2] = '{32'h99080019, 32'h00000000, 1'b0};  // brnz not taken
        vecs[3] = '{32'h99080019, 32'h80000000, 1'b1};  // brnz taken
        vecs[4] = '{32'h99100019, 32'h80000000, 1'b0};  // brpl not taken
        vecs[5] = '{32'h99180019, 32'h80000000, 1'b1};  // brmi taken
        vecs[6] = '{32'h99100019, 32'h00000005, 1'b1};  // brpl taken
        vecs[7] = '{32'h99180019, 32'h00000005, 1'b0};  // brmi not taken

        clear      = 1'b0;
        bif.start  = 1'b0;
        bif.hold   = 1'b0;
        bif.ir     = 32'h0;
        bif.bus_in = 32'h0;
        #2 check("reset_async", V_IDLE);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock); check("reset_idle", V_IDLE);

        // back-to-back: each run starts in the first IDLE cycle after the previous WRITE
        for (int i = 0; i < 8; i++) begin
            run_branch($sformatf("vec%0d", i), vecs[i].ir, vecs[i].bus, vecs[i].tk);
        end

        // illegal opcode start
        bif.ir    = 32'h18000000;
        bif.start = 1'b1;
        @(posedge clock);
        #1 bif.start = 1'b0;
        @(negedge clock); check("illegal_pulse", V_ILLEG);
        @(negedge clock); check("illegal_gone", V_IDLE);

        // hold in IDLE suppresses both illegal and valid starts
        bif.hold  = 1'b1;
        bif.start = 1'b1;
        @(negedge clock); check("hold_idle_illegal", V_IDLE);
        bif.ir = 32'h99000019;
        @(negedge clock); check("hold_idle_valid", V_IDLE);
        bif.start = 1'b0;
        bif.hold  = 1'b0;
        @(negedge clock); check("hold_idle_release", V_IDLE);

        // start pulsed during PCY is ignored
        bif.bus_in = 32'h0;
        bif.start  = 1'b1;
        @(posedge clock);
        #1 bif.start = 1'b0;
        @(negedge clock); check("ign_eval", V_EVAL);
        @(negedge clock); check("ign_pcy", V_PCY);
        bif.start = 1'b1;
        @(negedge clock); check("ign_add", V_ADD);
        bif.start = 1'b0;
        @(negedge clock); check("ign_write", V_WR_T);
        @(negedge clock); check("ign_idle1", V_IDLE);
        @(negedge clock); check("ign_idle2", V_IDLE);

        // hold for 3 cycles in WRITE: single delayed done/pc_in, latency 7
        bif.ir     = 32'h99000019;
        bif.bus_in = 32'h0;
        bif.start  = 1'b1;
        @(posedge clock);
        #1 bif.start = 1'b0;
        @(negedge clock); check("hw_eval", V_EVAL);
        @(negedge clock); check("hw_pcy", V_PCY);
        @(negedge clock); check("hw_add", V_ADD);
        @(posedge clock);
        #1 bif.hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge clock); check($sformatf("hw_held%0d", h), V_HELD);
            @(posedge clock);
        end
        #1 bif.hold = 1'b0;
        @(negedge clock); check("hw_write", V_WR_T);
        @(negedge clock); check("hw_idle", V_IDLE);

        // clear during ADD: immediate idle outputs, no pc_in afterward
        bif.start = 1'b1;
        @(posedge clock);
        #1 bif.start = 1'b0;
        @(negedge clock); check("clr_eval", V_EVAL);
        @(negedge clock); check("clr_pcy", V_PCY);
        @(negedge clock); check("clr_add", V_ADD);
        #2 clear = 1'b0;
        #1 check("clr_async", V_IDLE);
        @(negedge clock); check("clr_held", V_IDLE);
        clear = 1'b1;
        @(negedge clock); check("clr_after1", V_IDLE);
        @(negedge clock); check("clr_after2", V_IDLE);
        run_branch("post_clr", 32'h99080019, 32'h00000007, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Control sequencer for conditional branch instructions (brzr/brnz/brpl/brmi) in the datapath. On a start pulse from the main control unit it checks that the opcode is a branch, then drives the register-select, bus and latch strobes for each step. It evaluates the branch condition on the Ra value from the bus and holds the result in an internal CON flag. It then computes PC + C through Y/ALU/Z and writes PC only when the condition holds.

## Interface
Parameters:
- BR_OPCODE, 5'b10011, opcode value ir[31:27] that identifies a conditional branch

Ports:
- clock  input  1  system clock, rising-edge
- clear  input  1  asynchronous, active-low reset
- start  input  1  request to execute the branch in ir; sampled only in IDLE
- hold  input  1  stall: freezes state and forces all strobes low
- ir  input  32  instruction register; C2 = ir[20:19]; must stay stable while busy
- bus_in  input  32  datapath bus; carries Ra during EVAL
- gra  output  1  select Ra field for register-file read
- r_out  output  1  drive selected register onto bus
- con_in  output  1  CON evaluation strobe (status/observability)
- pc_out  output  1  drive PC onto bus
- y_in  output  1  load Y register
- c_out  output  1  drive sign-extended C field onto bus
- alu_add  output  1  ALU operation select = ADD
- z_in  output  1  load Z register
- z_lo_out  output  1  drive Z[31:0] onto bus
- pc_in  output  1  load PC from bus
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- taken  output  1  valid with done: branch taken
- illegal  output  1  one-cycle pulse: start seen with a non-branch opcode

## Operation
- States: IDLE, EVAL, PCY, ADD, WRITE.
- IDLE: if start=1 and hold=0 and ir[31:27]==BR_OPCODE, go to EVAL. If the opcode differs, pulse illegal for one cycle and stay in IDLE.
- EVAL: gra=r_out=con_in=1. On the exiting edge the block captures con_flag from bus_in using C2:
  - 00: bus_in==0
  - 01: bus_in!=0
  - 10: bus_in[31]==0
  - 11: bus_in[31]==1
- PCY: pc_out=y_in=1.
- ADD: c_out=alu_add=z_in=1.
- WRITE: z_lo_out=1, pc_in=con_flag, done=1, taken=con_flag. Next state is IDLE.
- Strobes are decoded from the state and gated by ~hold. Only one bus driver is active per state.
- start while busy is ignored; it is not queued.
- con_flag changes only on the edge leaving EVAL with hold=0. It keeps its value until the next EVAL so it can be read after done.
- taken is combinational: con_flag & done. It is 0 outside WRITE.

## Timing
- Reset (clear=0, asynchronous): state=IDLE, con_flag=0, illegal=0. All outputs are 0 immediately, with no clock needed.
- Start accepted at edge k: EVAL in cycle k+1, PCY k+2, ADD k+3, WRITE k+4 (done high), IDLE k+5. Four busy cycles with no stalls.
- Back-to-back: a start in the first IDLE cycle after WRITE is accepted, so at most one idle cycle between branches.
- hold=1 in any non-IDLE state: state frozen and strobes 0. hold=1 in WRITE delays done and pc_in, so PC is written exactly once. Latency grows by the number of held cycles.
- hold=1 in IDLE: start is ignored and illegal does not pulse.
- illegal is registered: it is high in cycle k+1 for an illegal start at edge k.
- clear asserted mid-sequence: return to IDLE and clear con_flag. pc_in is never asserted afterward for that instruction.

## Test plan
- brzr, taken: ir=0x99000019, bus_in=0x00000000 in EVAL, start pulse -> strobe sequence EVAL/PCY/ADD/WRITE on consecutive cycles, done=1, taken=1, pc_in=1 in cycle k+4.
- brnz, not taken: ir=0x99080019, bus_in=0 -> done=1, taken=0, pc_in=0; z_lo_out still 1 in WRITE.
- brpl and brmi: ir=0x99100019 with bus_in=0x80000000 -> taken=0; ir=0x99180019 with the same bus -> taken=1; brpl with bus_in=0x00000005 -> taken=1.
- Illegal and ignored starts: start with ir=0x18000000 -> illegal=1 for one cycle, busy stays 0; start pulsed during PCY -> no effect, single done.
- hold in WRITE for 3 cycles -> pc_in and done low during hold, then exactly one cycle of pc_in=1/done=1; total latency 7.
- clear pulsed low during ADD -> all outputs 0 asynchronously, state IDLE, con_flag=0, no pc_in; a following valid start completes normally.
